// File: rtl/clk_div_n.sv
// Programmable clock divider: fclk/N output, per-period tick, shadowed divisor.
// Define CLK_DIV_ODD_DUTY_EN for 50% duty on odd divisors (adds a negedge flop).
module clk_div_n #(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic             div_busy,
    output logic             div_err,
    output logic             running
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } state_t;

    localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] div_shd;
    logic [CNT_W-1:0] act_nxt;
    logic             pos_q;
    logic             wrap;
    logic             apply;
    logic             ld_ok;
    logic             ld_bad;
    logic             pos_nxt;
    logic             tick_nxt;

    always_comb begin
        wrap      = (state != IDLE) && (cnt == div_act - ONE);
        apply     = div_busy && ((state == IDLE) || wrap);
        ld_ok     = div_load && (div_in >= TWO);
        ld_bad    = div_load && (div_in < TWO);
        act_nxt   = apply ? div_shd : div_act;
        state_nxt = state;
        unique case (state)
            IDLE:    if (en) state_nxt = RUN;
            RUN:     if (!en) state_nxt = STOP;
            STOP: begin
                if (en)        state_nxt = RUN;
                else if (wrap) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if ((state == IDLE) || (state_nxt == IDLE) || wrap)
            cnt_nxt = '0;
        else
            cnt_nxt = cnt + ONE;
        // High-phase length floor(N/2) serves both even and odd divisors
        pos_nxt  = (state_nxt != IDLE) && (cnt_nxt < (act_nxt >> 1));
        tick_nxt = (state_nxt != IDLE) && (cnt_nxt == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            pos_q    <= 1'b0;
            tick     <= 1'b0;
            div_act  <= DEF;
            div_shd  <= DEF;
            div_busy <= 1'b0;
            div_err  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pos_q   <= pos_nxt;
            tick    <= tick_nxt;
            div_act <= act_nxt;
            div_err <= ld_bad;
            // Apply takes the old shadow; a same-cycle load still lands
            if (ld_ok) begin
                div_shd  <= div_in;
                div_busy <= 1'b1;
            end else if (apply) begin
                div_busy <= 1'b0;
            end
        end
    end

    assign running = (state != IDLE);

`ifdef CLK_DIV_ODD_DUTY_EN
    logic neg_q;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) neg_q <= 1'b0;
        else     neg_q <= pos_q;
    end

    // neg_q stretches the high phase by half a cycle on odd divisors
    assign clk_out = pos_q | (neg_q & div_act[0]);
`else
    assign clk_out = pos_q;
`endif

endmodule

// File: tb/tb_clk_div_n.sv
// Self-checking bench for clk_div_n: directed literal scenarios plus
// randomized traffic compared every half-cycle against a behavioural model.
module tb_clk_div_n;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             en;
    logic [CNT_W-1:0] div_in;
    logic             div_load;
    logic             clk_out;
    logic             tick;
    logic             div_busy;
    logic             div_err;
    logic             running;

    int checks   = 0;
    int failures = 0;

    clk_div_n #(.CNT_W(CNT_W), .DEF_DIV(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_in   (div_in),
        .div_load (div_load),
        .clk_out  (clk_out),
        .tick     (tick),
        .div_busy (div_busy),
        .div_err  (div_err),
        .running  (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: mode 0=idle 1=run 2=stop, phase within period, divisors
    int m_st, m_ph, m_act, m_shd, m_busy, m_err;

    // Output is high for the first hh half-cycles of an N-cycle period
    function automatic int hi_halves(input int d);
`ifdef CLK_DIV_ODD_DUTY_EN
        return d;
`else
        return 2 * (d / 2);
`endif
    endfunction

    task automatic m_reset();
        m_st = 0; m_ph = 0; m_act = 3; m_shd = 3; m_busy = 0; m_err = 0;
    endtask

    task automatic m_step(input bit e, input bit ld, input int din);
        bit end_of_period;
        bit take;
        int ns;
        end_of_period = (m_st != 0) && (m_ph == m_act - 1);
        take = (m_busy != 0) && (m_st == 0 || end_of_period);
        m_err = (ld && din < 2) ? 1 : 0;
        if (take) m_act = m_shd;
        if (ld && din >= 2) begin
            m_shd = din; m_busy = 1;
        end else if (take) begin
            m_busy = 0;
        end
        if (e) ns = 1;
        else if (m_st == 0) ns = 0;
        else if (m_st == 1) ns = 2;
        else ns = end_of_period ? 0 : 2;
        m_ph = (ns == 0 || m_st == 0 || end_of_period) ? 0 : m_ph + 1;
        m_st = ns;
    endtask

    // Compare process: every posedge+1 and negedge+1
    initial begin
        bit act_run;
        m_reset();
        forever begin
            @(posedge clk);
            if (rst) m_reset();
            else m_step(en, div_load, int'(div_in));
            #1;
            act_run = (m_st != 0) && !rst;
            chk("cmp_running", running, act_run);
            chk("cmp_tick", tick, act_run && m_ph == 0);
            chk("cmp_busy", div_busy, rst ? 0 : m_busy);
            chk("cmp_err", div_err, rst ? 0 : m_err);
            chk("cmp_clk_hi_half", clk_out,
                act_run && (2 * m_ph) < hi_halves(m_act));
            @(negedge clk);
            #1;
            act_run = (m_st != 0) && !rst;
            chk("cmp_clk_lo_half", clk_out,
                act_run && (2 * m_ph + 1) < hi_halves(m_act));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic rec(input int n, output logic [15:0] tv,
                       output logic [15:0] cv, output logic [15:0] rv,
                       output logic [15:0] bv);
        tv = '0; cv = '0; rv = '0; bv = '0;
        repeat (n) begin
            step();
            tv = {tv[14:0], tick};
            cv = {cv[14:0], clk_out};
            rv = {rv[14:0], running};
            bv = {bv[14:0], div_busy};
        end
    endtask

    task automatic wait_applied(input string nm);
        bit found;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (tick && !div_busy) found = 1;
        end
        chk(nm, found, 1);
    endtask

    initial begin
        logic [15:0] tv, cv, rv, bv;
        rst = 0; en = 0; div_load = 0; div_in = '0;
        #1 rst = 1;
        step();
        step();
        chk("rst_clk_out", clk_out, 0);
        chk("rst_tick", tick, 0);
        chk("rst_running", running, 0);
        chk("rst_busy", div_busy, 0);
        chk("rst_err", div_err, 0);

        // Default divide-by-3 from reset release
        en = 1; rst = 0;
        rec(6, tv, cv, rv, bv);
        chk("div3_tick", tv, 16'b100100);
`ifdef CLK_DIV_ODD_DUTY_EN
        chk("div3_clk", cv, 16'b110110);
`else
        chk("div3_clk", cv, 16'b100100);
`endif
        chk("div3_running", rv, 16'b111111);

        // Load 4 in mid-period: current period finishes first
        step();
        div_load = 1; div_in = 8'd4;
        step();
        div_load = 0;
        chk("load4_busy", div_busy, 1);
        rec(8, tv, cv, rv, bv);
        chk("load4_tick", tv, 16'b01000100);
        chk("load4_clk", cv, 16'b01100110);
        chk("load4_busy_seq", bv, 16'b10000000);

        // Illegal divisors 1 then 0
        div_load = 1; div_in = 8'd1;
        step();
        chk("err1_pulse", div_err, 1);
        div_in = 8'd0;
        step();
        chk("err0_pulse", div_err, 1);
        chk("err0_busy", div_busy, 0);
        div_load = 0;
        step();
        chk("err_clear", div_err, 0);
        chk("err_busy", div_busy, 0);
        rec(8, tv, cv, rv, bv);
        chk("err_keeps_div4", tv, 16'b00100010);

        // Divide by 6, drop en at cnt=1
        div_load = 1; div_in = 8'd6;
        step();
        div_load = 0;
        wait_applied("apply6_seen");
        step();
        en = 0;
        rec(6, tv, cv, rv, bv);
        chk("stop_running", rv, 16'b111100);
        chk("stop_clk", cv, 16'b100000);
        chk("stop_tick", tv, 16'b000000);

        // Reset while clk_out high
        en = 1;
        step();
        chk("pre_rst_clk", clk_out, 1);
        #1 rst = 1;
        #1;
        chk("async_rst_clk", clk_out, 0);
        chk("async_rst_running", running, 0);
        step();
        rst = 0;
        rec(6, tv, cv, rv, bv);
        chk("rst_div3_tick", tv, 16'b100100);

        // Divide by 5
        div_load = 1; div_in = 8'd5;
        step();
        div_load = 0;
        wait_applied("apply5_seen");
        chk("div5_first", clk_out, 1);
        rec(5, tv, cv, rv, bv);
`ifdef CLK_DIV_ODD_DUTY_EN
        chk("div5_clk", cv, 16'b11001);
`else
        chk("div5_clk", cv, 16'b10001);
`endif

        // Randomized traffic
        repeat (3000) begin
            if ($urandom_range(0, 7) == 0) en = ~en;
            div_load = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) div_in = 8'($urandom_range(0, 255));
            else div_in = 8'($urandom_range(0, 12));
            if (rst) rst = 0;
            else rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 0; div_load = 0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
